// File: rtl/seven_seg_scan_driver_pkg.sv
// Shared constants and types for the seven-segment scan driver and its decoder.
// Digit codes 14/15 are the decoder's blank and minus glyphs.
package seven_seg_scan_driver_pkg;

  localparam logic [3:0] DIGIT_BLANK = 4'd14;
  localparam logic [3:0] DIGIT_MINUS = 4'd15;
  localparam int         BIN_W       = 8;
  localparam int         BCD_W       = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } conv_state_t;

  // Double-dabble correction applied to each BCD nibble before the shift.
  function automatic logic [3:0] dabble_adj(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/seven_seg_scan_driver_if.sv
// Load/status/display bundle between the datapath, the scan driver and the segment decoder.
// Handshake: value is sampled on any clk edge where load=1 and busy=0; done pulses once per committed value.
interface seven_seg_scan_driver_if;
  import seven_seg_scan_driver_pkg::*;

  logic [7:0]  value;
  logic        load;
  logic        busy;
  logic        done;
  logic [1:0]  en;
  logic [3:0]  num;
  conv_state_t state;

  modport master (output value, load, input busy, done, en, num, state);
  modport slave  (input value, load, output busy, done, en, num, state);

endinterface

// File: rtl/seven_seg_scan_driver_bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (double dabble), one bit per clock.
// start is accepted only while idle; done pulses the cycle after the eighth shift.
module bin2bcd_seq
  import seven_seg_scan_driver_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  logic [BIN_W-1:0] mag;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] adj;
  logic [2:0]       iter;
  logic             running;
  logic             done_q;

  always_comb begin
    adj = {dabble_adj(bcd_q[11:8]), dabble_adj(bcd_q[7:4]), dabble_adj(bcd_q[3:0])};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mag     <= '0;
      bcd_q   <= '0;
      iter    <= '0;
      running <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (running) begin
        {bcd_q, mag} <= {adj, mag} << 1;
        iter         <= iter + 3'd1;
        if (iter == 3'd7) begin
          running <= 1'b0;
          done_q  <= 1'b1;
        end
      end else if (start) begin
        mag     <= bin;
        bcd_q   <= '0;
        iter    <= '0;
        running <= 1'b1;
      end
    end
  end

  assign busy = running;
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Converts a signed 8-bit value to sign + 3 BCD digits and time-multiplexes
// the four digit codes onto en/num for the per-digit segment decoder.
module seven_seg_scan_driver
  import seven_seg_scan_driver_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  seven_seg_scan_driver_if.slave bus
);

  localparam int              CW       = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]   CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [3:0]      RST_HT   = BLANK_LZ ? DIGIT_BLANK : 4'd0;

  conv_state_t      state, state_next;
  logic             conv_start, conv_busy, conv_done, commit;
  logic [BCD_W-1:0] conv_bcd;
  logic [7:0]       mag_in;
  logic             neg_q;
  logic [3:0]       code      [4];
  logic [3:0]       disp      [4];
  logic [3:0]       disp_next [4];
  logic [CW-1:0]    cnt;
  logic [1:0]       en_q, en_adv;
  logic [3:0]       num_q;

  assign mag_in = bus.value[7] ? (~bus.value + 8'd1) : bus.value;

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (mag_in),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      neg_q <= 1'b0;
    end else begin
      state <= state_next;
      if (conv_start) neg_q <= bus.value[7];
    end
  end

  always_comb begin
    state_next = state;
    conv_start = 1'b0;
    case (state)
      IDLE: begin
        if (bus.load && !conv_busy) begin
          conv_start = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT:   if (conv_done) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Digits are written on the edge that enters COMMIT, so done and the new
  // display contents become visible together.
  assign commit = (state == SHIFT) && conv_done;

  always_comb begin
    code[3] = neg_q ? DIGIT_MINUS : DIGIT_BLANK;
    code[2] = conv_bcd[11:8];
    code[1] = conv_bcd[7:4];
    code[0] = conv_bcd[3:0];
    if (BLANK_LZ) begin
      if (conv_bcd[11:8] == 4'd0) code[2] = DIGIT_BLANK;
      if (conv_bcd[11:4] == 8'd0) code[1] = DIGIT_BLANK;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      disp_next[i] = commit ? code[i] : disp[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp[3] <= DIGIT_BLANK;
      disp[2] <= RST_HT;
      disp[1] <= RST_HT;
      disp[0] <= 4'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        disp[i] <= disp_next[i];
      end
    end
  end

  // Scanner reads disp_next so a commit landing on a wrap shows the new digit at once.
  assign en_adv = en_q + 2'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      en_q  <= 2'd0;
      num_q <= 4'd0;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      en_q  <= en_adv;
      num_q <= disp_next[en_adv];
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bus.busy  = (state != IDLE);
  assign bus.done  = (state == COMMIT);
  assign bus.en    = en_q;
  assign bus.num   = num_q;
  assign bus.state = state;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: two instances (blanking on/off) share stimulus;
// a scoreboard queue holds expected digits and done cycles, a monitor tracks the scan.
module tb_seven_seg_scan_driver;
  import seven_seg_scan_driver_pkg::*;

  localparam int RD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seven_seg_scan_driver_if bus_lz();
  seven_seg_scan_driver_if bus_nz();

  seven_seg_scan_driver #(.REFRESH_DIV(RD), .BLANK_LZ(1'b1)) dut_lz (.clk(clk), .rst(rst), .bus(bus_lz));
  seven_seg_scan_driver #(.REFRESH_DIV(RD), .BLANK_LZ(1'b0)) dut_nz (.clk(clk), .rst(rst), .bus(bus_nz));

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Entry: {due cycle[63:32], digits blanking-on[31:16], digits blanking-off[15:0]}
  logic [63:0] exp_q[$];
  int          last_e = 0;
  bit          have_e = 1'b0;

  logic [3:0] disp_lz [4];
  logic [3:0] disp_nz [4];
  logic [1:0] en_m = 2'd0;
  logic [1:0] exp_en;
  logic [3:0] num_lz_m = 4'd0;
  logic [3:0] num_nz_m = 4'd0;
  int         last_wrap = 0;
  bit         wrap, exp_busy, exp_done;
  logic [63:0] ent;
  int         exp_state;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: decimal digits by plain division, then sign/blanking rules.
  function automatic logic [15:0] ref_digits(input int v, input bit blank_lz);
    int m, h, t, u;
    logic [3:0] s, hc, tc;
    m  = (v < 0) ? -v : v;
    h  = m / 100;
    t  = (m / 10) % 10;
    u  = m % 10;
    s  = (v < 0) ? DIGIT_MINUS : DIGIT_BLANK;
    hc = 4'(h);
    tc = 4'(t);
    if (blank_lz && h == 0) hc = DIGIT_BLANK;
    if (blank_lz && h == 0 && t == 0) tc = DIGIT_BLANK;
    return {s, hc, tc, 4'(u)};
  endfunction

  task automatic set_disp(input logic [15:0] lz, input logic [15:0] nz);
    for (int i = 0; i < 4; i++) begin
      disp_lz[i] = lz[4*i +: 4];
      disp_nz[i] = nz[4*i +: 4];
    end
  endtask

  // Called at negedge+1; load is sampled on edge cyc+1.
  task automatic issue_load(input int v);
    int e;
    bus_lz.value = 8'(v);
    bus_nz.value = 8'(v);
    bus_lz.load  = 1'b1;
    bus_nz.load  = 1'b1;
    e = cyc + 1;
    if (!have_e || e > last_e + 10) begin
      exp_q.push_back({32'(e + 9), ref_digits(v, 1'b1), ref_digits(v, 1'b0)});
      last_e = e;
      have_e = 1'b1;
    end
    @(negedge clk); #1;
    bus_lz.load = 1'b0;
    bus_nz.load = 1'b0;
  endtask

  task automatic drive_load(input int v);
    @(negedge clk); #1;
    issue_load(v);
  endtask

  // Wait until a load now would commit on the same edge the scan wraps onto en=0.
  task automatic drive_aligned(input int v);
    int k;
    for (int tries = 0; tries < 64; tries++) begin
      @(negedge clk); #1;
      k = cyc + 1 + 9 - last_wrap;
      if ((k % RD) == 0 && ((int'(en_m) + k / RD) % 4) == 0) break;
    end
    issue_load(v);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk); #1;
    rst    = 1'b1;
    have_e = 1'b0;
    exp_q.delete();
    repeat (n) @(negedge clk);
    #1 rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      check("rst_en",    int'(bus_lz.en),    0);
      check("rst_num",   int'(bus_lz.num),   0);
      check("rst_busy",  int'(bus_lz.busy),  0);
      check("rst_done",  int'(bus_lz.done),  0);
      check("rst_state", int'(bus_lz.state), int'(IDLE));
      check("rst_nz_num", int'(bus_nz.num),  0);
      set_disp({DIGIT_BLANK, DIGIT_BLANK, DIGIT_BLANK, 4'd0}, {DIGIT_BLANK, 12'h000});
      en_m      = 2'd0;
      num_lz_m  = 4'd0;
      num_nz_m  = 4'd0;
      last_wrap = cyc;
    end else begin
      exp_busy = have_e && cyc >= last_e && cyc <= last_e + 9;
      exp_done = 1'b0;
      if (exp_q.size() > 0) begin
        ent = exp_q[0];
        exp_done = (int'(ent[63:32]) == cyc);
      end
      check("busy_lz", int'(bus_lz.busy), int'(exp_busy));
      check("busy_nz", int'(bus_nz.busy), int'(exp_busy));
      check("done_lz", int'(bus_lz.done), int'(exp_done));
      check("done_nz", int'(bus_nz.done), int'(exp_done));
      exp_state = exp_done ? int'(COMMIT) : (exp_busy ? int'(SHIFT) : int'(IDLE));
      check("state_lz", int'(bus_lz.state), exp_state);
      if (exp_done) begin
        ent = exp_q.pop_front();
        set_disp(ent[31:16], ent[15:0]);
      end
      wrap   = ((cyc - last_wrap) == RD);
      exp_en = wrap ? en_m + 2'd1 : en_m;
      check("en_lz", int'(bus_lz.en), int'(exp_en));
      check("en_nz", int'(bus_nz.en), int'(exp_en));
      if (wrap) begin
        en_m      = exp_en;
        num_lz_m  = disp_lz[en_m];
        num_nz_m  = disp_nz[en_m];
        last_wrap = cyc;
      end
      check("num_lz", int'(bus_lz.num), int'(num_lz_m));
      check("num_nz", int'(bus_nz.num), int'(num_nz_m));
    end
  end

  int directed[8] = '{127, -128, -5, 0, -1, 100, -100, 10};

  initial begin
    bus_lz.value = 8'd0; bus_lz.load = 1'b0;
    bus_nz.value = 8'd0; bus_nz.load = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    idle(20);

    foreach (directed[i]) begin
      drive_load(directed[i]);
      idle(20);
    end

    // Second load lands while busy and must be dropped.
    drive_load(42);
    idle(2);
    drive_load(99);
    idle(25);

    // Reset in the middle of a conversion.
    drive_load(100);
    idle(4);
    do_reset(2);
    idle(20);
    drive_load(100);
    idle(20);

    drive_aligned(9);
    idle(20);

    for (int n = 0; n < 40; n++) begin
      drive_load(int'($urandom_range(0, 255)) - 128);
      idle($urandom_range(0, 14));
    end

    for (int w = 0; w < 50 && exp_q.size() > 0; w++) @(negedge clk);
    check("drain", exp_q.size(), 0);
    idle(20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_driver.md
Name: seven_seg_scan_driver

Overview:
Drives the digit-multiplexed 4-digit seven-segment display by generating the en[1:0] digit-select and num[3:0] digit-code inputs that the per-digit segment decoder consumes. Accepts a signed 8-bit value on a load strobe and converts it to sign and BCD digits with a sequential double-dabble converter. Time-multiplexes the four digits at a programmable refresh rate. Sits between the datapath/result register and the segment decoder in the board top level.

Parameters:
REFRESH_DIV, 100000, clock cycles each digit stays selected (1 ms at 100 MHz); legal range >=2.
BLANK_LZ, 1, 1 = leading-zero blanking on hundreds/tens digits; 0 = always show all three magnitude digits.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  synchronous active-high reset.
value  input  8  signed two's-complement value to display (-128..127).
load  input  1  single-cycle strobe; samples value when not busy.
busy  output  1  high while a conversion is in progress.
done  output  1  one-cycle pulse when new digits are committed to the display.
en  output  2  digit select to decoder; 0 = units (rightmost), 1 = tens, 2 = hundreds, 3 = sign (leftmost).
num  output  4  digit code to decoder; 0-9 = decimal digit, 14 = blank, 15 = minus.

Behaviour:
- Reset (synchronous, active-high, clk, rst): busy=0, done=0, en=2'b00, num=4'd0; refresh counter=0; converter in IDLE; committed digits = sign 14, hundreds 14, tens 14, units 0 when BLANK_LZ=1; with BLANK_LZ=0 they are 14,0,0,0. Reset mid-conversion aborts it, and no done pulse is produced.
- Converter FSM: IDLE -> SHIFT -> COMMIT -> IDLE.
- IDLE: load=1 captures the sign bit value[7] and magnitude |value| as 8-bit unsigned (-128 -> 128). It clears the 12-bit BCD shift register and moves to SHIFT; busy goes high on the same edge.
- SHIFT: exactly 8 cycles. Each cycle, add 3 to every BCD nibble >=5, then shift {bcd,mag} left by 1. A 3-bit iteration counter tracks the cycles.
- COMMIT: one cycle. Register the digit codes into the display registers, assert done for this cycle, and drop busy on exit.
- Latency: if load is sampled at edge E, done is high during the cycle following edge E+9, and the new digits appear on num from the next scan update. busy is high from E through E+9 inclusive.
- load while busy: ignored, with no queueing. Any load asserted during the COMMIT cycle is also ignored.
- Digit codes: sign = 15 if negative, else 14. With BLANK_LZ=1, hundreds = 14 if 0; tens = 14 if hundreds==0 and tens==0. Units are never blanked. Example: -5 -> {15,14,14,5}.
- Display registers change only in COMMIT, so the scanner never shows a partially converted value.
- Scanner runs independently of the converter. The refresh counter counts 0..REFRESH_DIV-1. On wrap, en advances 0->1->2->3->0, and num is registered on the same edge to the code for the new en. Both are registered outputs, with no combinational path from value or load.
- If COMMIT coincides with a scan wrap, num takes the newly committed digit.

Decomposition:
- Shared package: DIGIT_BLANK=4'd14 and DIGIT_MINUS=4'd15 (shared with the segment decoder); the converter state enum {IDLE, SHIFT, COMMIT}.
- Sub-module bin2bcd_seq contains the 8-bit sequential double-dabble with start/busy/done handshake and 12-bit BCD output. The top level adds sign handling, blanking, display registers and the scanner.

Test Plan:
- Reset held 3 cycles, REFRESH_DIV=4 -> en=0, num=0, busy=0, done=0; after release, en steps 0,1,2,3,0 every 4 cycles; num is 0,14,14,14 (BLANK_LZ=1).
- load value=127 (8'h7F) -> busy for 10 edges, done pulse at E+9; scan shows units 7, tens 2, hundreds 1, sign 14.
- load value=-128 (8'h80) -> digits {15,1,2,8}. load value=-5 (8'hFB) -> {15,14,14,5}; with BLANK_LZ=0 -> {15,0,0,5}.
- load 42, then load 99 asserted 3 cycles later while busy -> only one done pulse; display shows {14,14,4,2}.
- rst asserted during SHIFT of a load of 100 -> no done pulse; display returns to reset digits; a subsequent load of 100 shows {14,1,0,0}.
- COMMIT aligned with a scan wrap onto en=0 (load 9 at a computed cycle) -> num=9 on that same edge, with no stale value.
